// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: owns the fetch PC and issues in-order imem reads under a credit limit.
// It queues PC-tagged words for decode; a redirect flushes the queue and drops in-flight data.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_instr_mem [DEPTH];
    logic [31:0]   r_pc_mem    [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_grant;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_pc;

    // Credits cover queued entries plus in-flight reads, so a response always finds a free slot.
    always_comb begin
        w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
        imem_req      = rst && !redirect && (w_credit_used < LIMIT);
        imem_addr     = r_fetch_pc;
        w_grant       = imem_req && imem_gnt;
        w_resp        = imem_rvalid && (r_outstanding != '0);
        w_drop        = w_resp && (r_drop_cnt != '0);
        w_push        = w_resp && !w_drop && !redirect;
        instr_valid   = (r_count != '0);
        w_pop         = instr_valid && instr_ready && !redirect;
        w_head_pc     = r_pc_mem[r_rd_ptr];
        instr         = instr_valid ? r_instr_mem[r_rd_ptr] : '0;
        pc            = instr_valid ? w_head_pc : '0;
        pc_plus4      = instr_valid ? (w_head_pc + 32'd4) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect) begin
            r_fetch_pc    <= redirect_pc;
            r_resp_pc     <= redirect_pc;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= r_outstanding - CW'(w_resp);
            // Every read still in flight is stale, including ones already marked for dropping.
            r_drop_cnt    <= r_outstanding - CW'(w_resp);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_resp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and randomised bench for fetch_buffer. The reference tracks granted addresses per
// redirect epoch and the decode-visible queue of {word, address} at transaction level.
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] word; logic [31:0] addr; } ent_t;

    req_t        inflight[$];
    ent_t        expQ[$];
    logic [31:0] modelPc;
    int          epoch, cyc, tests, failures, dutGrants;
    int          gntPct, readyPct, rvalidPct, latFix, latJit, spurPct;
    logic        found;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5} + 32'h0101_0101;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model past the rising edge.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
        bit   expReq, grantNow, popNow, respNow, spur;
        req_t r;
        req_t nr;
        ent_t e;
        @(negedge clk);
        respNow = (inflight.size() != 0) && (inflight[0].due <= cyc) &&
                  (int'($urandom_range(99)) < rvalidPct);
        spur = (inflight.size() == 0) && (int'($urandom_range(99)) < spurPct);
        redirect    = redir;
        redirect_pc = rpc;
        imem_gnt    = (int'($urandom_range(99)) < gntPct);
        instr_ready = (int'($urandom_range(99)) < readyPct);
        imem_rvalid = respNow || spur;
        imem_rdata  = respNow ? memWord(inflight[0].addr) : $urandom;
        #1;
        expReq = !redir && ((expQ.size() + inflight.size()) < DEPTH);
        checkOutput("instr_valid", 32'(instr_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkOutput("instr", instr, expQ[0].word);
            checkOutput("pc", pc, expQ[0].addr);
            checkOutput("pc_plus4", pc_plus4, expQ[0].addr + 32'd4);
        end
        checkOutput("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) checkOutput("imem_addr", imem_addr, modelPc);
        if (imem_req && imem_gnt) dutGrants++;

        grantNow = expReq && imem_gnt;
        popNow   = (expQ.size() != 0) && instr_ready;
        r        = '{addr: 32'd0, epoch: -1, due: 0};
        if (respNow) r = inflight.pop_front();
        if (redir) begin
            epoch++;
            expQ.delete();
            modelPc = rpc;
        end else begin
            if (popNow) expQ.delete(0);
            if (respNow && r.epoch == epoch) begin
                e.word = memWord(r.addr);
                e.addr = r.addr;
                expQ.push_back(e);
            end
            if (grantNow) begin
                nr.addr  = modelPc;
                nr.epoch = epoch;
                nr.due   = cyc + 1 + latFix + int'($urandom_range(latJit));
                inflight.push_back(nr);
                modelPc += 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    // Asserts reset between edges, checks outputs fall with no clock, releases on a falling edge.
    task automatic doReset();
        #2;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        rst         = 1'b0;
        #1;
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_pc_plus4", pc_plus4, 32'd0);
        inflight.delete();
        expQ.delete();
        epoch++;
        modelPc = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitValid(input int budget);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            applyStimulus(1'b0, 32'd0);
            #1;
            found = instr_valid;
        end
        checkOutput("wait_valid", 32'(found), 32'd1);
    endtask

    initial begin
        tests = 0; failures = 0; cyc = 0; epoch = 0; dutGrants = 0;
        modelPc = RESET_PC;
        redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; instr_ready = 1'b0;
        gntPct = 100; readyPct = 100; rvalidPct = 100; latFix = 0; latJit = 0; spurPct = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        doReset();

        // Streaming with single-cycle memory: first word visible two edges after the first grant.
        applyStimulus(1'b0, 32'd0);
        applyStimulus(1'b0, 32'd0);
        #1;
        checkOutput("t1_first_valid", 32'(instr_valid), 32'd1);
        checkOutput("t1_first_pc", pc, RESET_PC);
        checkOutput("t1_first_pc4", pc_plus4, RESET_PC + 32'd4);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0);

        // Decode stalled: credit limit stops issue after DEPTH grants.
        doReset();
        readyPct = 0;
        dutGrants = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'd0);
        #1;
        checkOutput("t2_grants", dutGrants, 32'd4);
        checkOutput("t2_req_low", 32'(imem_req), 32'd0);
        checkOutput("t2_head_pc", pc, 32'd0);
        readyPct = 100;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("t2_resumed", 32'(dutGrants > 4), 32'd1);

        // Redirect with two reads in flight.
        doReset();
        latFix = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h0000_0100);
        #1;
        checkOutput("t3_flushed", 32'(instr_valid), 32'd0);
        waitValid(20);
        checkOutput("t3_pc", pc, 32'h0000_0100);
        checkOutput("t3_instr", instr, memWord(32'h0000_0100));

        // Redirect coinciding with a response and a pop.
        latFix = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0);
        applyStimulus(1'b1, 32'h0000_0200);
        #1;
        checkOutput("t4_flushed", 32'(instr_valid), 32'd0);
        waitValid(20);
        checkOutput("t4_pc", pc, 32'h0000_0200);

        // Fetch PC wrap at the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFC);
        waitValid(20);
        checkOutput("t5_pc", pc, 32'hFFFF_FFFC);
        checkOutput("t5_pc_plus4", pc_plus4, 32'h0000_0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0);

        // Asynchronous reset with three entries queued.
        readyPct = 0;
        for (int i = 0; i < 20 && expQ.size() != 3; i++) applyStimulus(1'b0, 32'd0);
        #1;
        checkOutput("t6_queued", 32'(instr_valid), 32'd1);
        doReset();
        readyPct = 100;
        waitValid(20);
        checkOutput("t6_restart_pc", pc, RESET_PC);

        // Randomised traffic: variable latency, back-pressure, redirects and spurious responses.
        gntPct = 70; readyPct = 60; rvalidPct = 70; latJit = 3; spurPct = 10;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            bit          redir;
            redir = (int'($urandom_range(99)) < 5);
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 + ($urandom_range(3) << 2);
            else                        rpc = $urandom & 32'hFFFF_FFFC;
            if (i == 300) doReset();
            applyStimulus(redir, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
